// File: rtl/horner_ctrl_if.sv
// horner_ctrl_if: requester/datapath handshake bundle of the Horner controller
interface horner_ctrl_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 3
);
  logic                  start_i;
  logic [DATA_WIDTH-1:0] x_i;
  logic [ADDR_WIDTH-1:0] order_i;
  logic                  coeff_we_i;
  logic [ADDR_WIDTH-1:0] coeff_waddr_i;
  logic [DATA_WIDTH-1:0] coeff_wdata_i;
  logic                  add_done_i;
  logic                  mul_done_i;
  logic [DATA_WIDTH-1:0] signal_o;
  logic [DATA_WIDTH-1:0] coeff_o;
  logic                  add_valid_o;
  logic                  mul_valid_o;
  logic                  load_result_o;
  logic                  busy_o;
  logic                  done_o;
  logic                  error_o;
  modport master (
    output start_i, x_i, order_i, coeff_we_i, coeff_waddr_i, coeff_wdata_i, add_done_i, mul_done_i,
    input  signal_o, coeff_o, add_valid_o, mul_valid_o, load_result_o, busy_o, done_o, error_o
  );
  modport slave (
    input  start_i, x_i, order_i, coeff_we_i, coeff_waddr_i, coeff_wdata_i, add_done_i, mul_done_i,
    output signal_o, coeff_o, add_valid_o, mul_valid_o, load_result_o, busy_o, done_o, error_o
  );
endinterface

// File: rtl/horner_ctrl.sv
// horner_ctrl: sequences an FP32 mul/add datapath through a Horner polynomial evaluation
module horner_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int MAX_ORDER  = 7,
  parameter int ADDR_WIDTH = 3,
  parameter int TIMEOUT    = 64
) (
  input logic          clk_i,
  input logic          rst_i,
  horner_ctrl_if.slave bus
);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [ADDR_WIDTH-1:0] MAX_N = ADDR_WIDTH'(MAX_ORDER);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);
  typedef enum logic [3:0] {
    IDLE, SEED_S, SEED_V, SEED_W, ADD_S, ADD_V, ADD_W, MUL_S, MUL_V, MUL_W, LOAD, DONE
  } state_t;
  state_t state, nxt;
  logic [DATA_WIDTH-1:0] bank [0:MAX_ORDER];
  logic [DATA_WIDTH-1:0] x_q, c_q;
  logic [ADDR_WIDTH-1:0] k;
  logic [CW-1:0] cnt;
  logic err, accept, wait_st, tmo;
  assign accept  = state == IDLE && bus.start_i;
  assign wait_st = state inside {SEED_W, ADD_W, MUL_W};
  assign tmo     = cnt == LAST;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = bus.start_i ? SEED_S : IDLE;
      SEED_S:  nxt = SEED_V;
      SEED_V:  nxt = SEED_W;
      SEED_W:  nxt = bus.mul_done_i ? ADD_S : tmo ? DONE : SEED_W;
      ADD_S:   nxt = ADD_V;
      ADD_V:   nxt = ADD_W;
      ADD_W:   nxt = bus.add_done_i ? (k == '0 ? LOAD : MUL_S) : tmo ? DONE : ADD_W;
      MUL_S:   nxt = MUL_V;
      MUL_V:   nxt = MUL_W;
      MUL_W:   nxt = bus.mul_done_i ? ADD_S : tmo ? DONE : MUL_W;
      LOAD:    nxt = DONE;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
      x_q   <= '0;
      c_q   <= '0;
      k     <= '0;
      cnt   <= '0;
      err   <= 1'b0;
    end else begin
      state <= nxt;
      cnt   <= wait_st ? cnt + 1'b1 : '0;
      err   <= accept ? 1'b0 : (wait_st && nxt == DONE) ? 1'b1 : err;
      if (accept) begin
        x_q <= bus.x_i;
        k   <= bus.order_i > MAX_N ? MAX_N : bus.order_i;
      end
      if (state == ADD_W && bus.add_done_i && k != '0) k <= k - 1'b1;
      // the coefficient is frozen once set up so later writes only affect later steps
      if (state == ADD_S) c_q <= bank[k];
    end
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i <= MAX_ORDER; i++) bank[i] <= '0;
    end else if (bus.coeff_we_i && bus.coeff_waddr_i <= MAX_N) begin
      bank[bus.coeff_waddr_i] <= bus.coeff_wdata_i;
    end
  end
  assign bus.signal_o      = state inside {MUL_S, MUL_V, MUL_W} ? x_q : '0;
  assign bus.coeff_o       = state == ADD_S ? bank[k] : state inside {ADD_V, ADD_W} ? c_q : '0;
  assign bus.add_valid_o   = state == ADD_V;
  assign bus.mul_valid_o   = state inside {SEED_V, MUL_V};
  assign bus.load_result_o = state == LOAD;
  assign bus.busy_o        = state != IDLE;
  assign bus.done_o        = state == DONE;
  assign bus.error_o       = err;
endmodule

// File: tb/tb_horner_ctrl.sv
// tb_horner_ctrl: directed bench with done responders and a behavioural FP32 datapath
module tb_horner_ctrl;
  localparam int DW = 32, AW = 3, TIMEOUT = 64;
  logic clk = 1'b0, rst = 1'b1;
  int cyc = 0, checks = 0, errors = 0;
  int lat = 1, mtimer = 0, atimer = 0, withhold = 0, stray = 0;
  int n_mul, n_add, n_load, n_done, done_cyc, mul2_cyc;
  int kind_q[$];
  logic [DW-1:0] data_q[$];
  real acc_add, acc_mul;
  logic [DW-1:0] result;
  logic err_at_done;
  horner_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();
  horner_ctrl #(.DATA_WIDTH(DW), .MAX_ORDER(7), .ADDR_WIDTH(AW), .TIMEOUT(TIMEOUT)) dut (
    .clk_i(clk), .rst_i(rst), .bus(bus.slave)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic real to_real(input logic [31:0] b);
    logic [63:0] d;
    if (b[30:23] == 8'd0) d = {b[31], 63'd0};
    else d = {b[31], 11'(b[30:23]) + 11'd896, b[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction
  function automatic logic [31:0] to_bits(input real r);
    logic [63:0] d;
    d = $realtobits(r);
    if (d[62:52] == 11'd0) return {d[63], 31'd0};
    return {d[63], 8'(d[62:52] - 11'd896), d[51:29]};
  endfunction
  function automatic logic [69:0] outs();
    return {bus.signal_o, bus.coeff_o, bus.add_valid_o, bus.mul_valid_o,
            bus.load_result_o, bus.busy_o, bus.done_o, bus.error_o};
  endfunction
  // done responders (latency lat after valid) and the mul/add datapath they stand for
  always @(negedge clk) begin
    if (rst) begin
      mtimer = 0;
      atimer = 0;
      bus.mul_done_i = 1'b0;
      bus.add_done_i = 1'b0;
    end else begin
      bus.mul_done_i = mtimer == 1;
      bus.add_done_i = atimer == 1 || (stray != 0 && mtimer >= 2);
      if (mtimer > 0) mtimer--;
      if (atimer > 0) atimer--;
      if (bus.mul_valid_o) begin
        n_mul++;
        kind_q.push_back(1);
        data_q.push_back(bus.signal_o);
        acc_mul = acc_add * to_real(bus.signal_o);
        if (n_mul == 2) mul2_cyc = cyc;
        if (n_mul != withhold) mtimer = lat;
      end
      if (bus.add_valid_o) begin
        n_add++;
        kind_q.push_back(2);
        data_q.push_back(bus.coeff_o);
        acc_add = acc_mul + to_real(bus.coeff_o);
        atimer = lat;
      end
      if (bus.load_result_o) begin
        n_load++;
        kind_q.push_back(3);
        data_q.push_back('0);
        result = to_bits(acc_add);
      end
      if (bus.done_o) begin
        n_done++;
        kind_q.push_back(4);
        data_q.push_back('0);
        done_cyc = cyc;
        err_at_done = bus.error_o;
      end
    end
  end
  task automatic clear_log();
    n_mul = 0; n_add = 0; n_load = 0; n_done = 0; done_cyc = -1; mul2_cyc = -1;
    kind_q.delete();
    data_q.delete();
    acc_add = 0.0; acc_mul = 0.0;
    result = '0;
    err_at_done = 1'b0;
  endtask
  task automatic write_coeff(input int k, input logic [DW-1:0] v);
    @(posedge clk); #1;
    bus.coeff_we_i = 1'b1; bus.coeff_waddr_i = AW'(k); bus.coeff_wdata_i = v;
    @(posedge clk); #1;
    bus.coeff_we_i = 1'b0;
  endtask
  task automatic start_run(input logic [AW-1:0] n, input logic [DW-1:0] x, output int s);
    @(posedge clk); #1;
    bus.start_i = 1'b1; bus.order_i = n; bus.x_i = x;
    s = cyc;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
  endtask
  task automatic wait_done(input string name);
    for (int i = 0; i < 2000 && n_done == 0; i++) @(posedge clk);
    @(negedge clk);
    checks++;
    if (n_done == 0) begin
      errors++;
      $display("FAIL %s_done_timeout: done_o count %0d, required >= 1", name, n_done);
    end
  endtask
  task automatic test_reset();
    int s;
    checks++;
    if (outs() !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %h, required 0", outs());
    end
    write_coeff(0, 32'h3F800000);
    lat = 3;
    clear_log();
    start_run(0, 32'h40000000, s);
    for (int i = 0; i < 100 && n_add == 0; i++) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    checks++;
    if (outs() !== '0) begin
      errors++;
      $display("FAIL async_reset_outputs: got %h, required 0", outs());
    end
    #3 rst = 1'b0;
    lat = 1;
    clear_log();
    start_run(0, 32'h40000000, s);
    wait_done("readback");
    checks++;
    if (kind_q.size() != 4) begin
      errors++;
      $display("FAIL readback_len: got %0d pulses, required 4", kind_q.size());
    end else begin
      checks++;
      if (data_q[1] !== 32'h0) begin
        errors++;
        $display("FAIL readback_coeff: got %h, required 00000000", data_q[1]);
      end
    end
  endtask
  task automatic test_order2();
    int s;
    int exp_k[8];
    logic [DW-1:0] exp_d[8];
    exp_k = '{1, 2, 1, 2, 1, 2, 3, 4};
    exp_d = '{32'h0, 32'h40400000, 32'h40000000, 32'h40000000, 32'h40000000, 32'h3F800000, 32'h0, 32'h0};
    write_coeff(0, 32'h3F800000);
    write_coeff(1, 32'h40000000);
    write_coeff(2, 32'h40400000);
    lat = 3;
    clear_log();
    start_run(2, 32'h40000000, s);
    wait_done("order2");
    checks++;
    if (kind_q.size() != 8) begin
      errors++;
      $display("FAIL order2_len: got %0d pulses, required 8", kind_q.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (kind_q[i] != exp_k[i] || data_q[i] !== exp_d[i]) begin
          errors++;
          $display("FAIL order2_pulse%0d: got kind %0d data %h, required kind %0d data %h",
                   i, kind_q[i], data_q[i], exp_k[i], exp_d[i]);
        end
      end
    end
    checks++;
    if (n_mul != 3 || n_add != 3) begin
      errors++;
      $display("FAIL order2_counts: got mul %0d add %0d, required 3 3", n_mul, n_add);
    end
    checks++;
    if (result !== 32'h41880000) begin
      errors++;
      $display("FAIL order2_result: got %h, required 41880000", result);
    end
    checks++;
    if (done_cyc - s != 32) begin
      errors++;
      $display("FAIL order2_latency: got %0d, required 32", done_cyc - s);
    end
  endtask
  task automatic test_order0();
    int s;
    write_coeff(0, 32'hBF000000);
    lat = 1;
    clear_log();
    start_run(0, 32'h40000000, s);
    wait_done("order0");
    checks++;
    if (done_cyc - s != 8) begin
      errors++;
      $display("FAIL order0_latency: got %0d, required 8", done_cyc - s);
    end
    checks++;
    if (n_mul != 1 || n_add != 1 || n_load != 1) begin
      errors++;
      $display("FAIL order0_counts: got mul %0d add %0d load %0d, required 1 1 1", n_mul, n_add, n_load);
    end
    checks++;
    if (result !== 32'hBF000000) begin
      errors++;
      $display("FAIL order0_result: got %h, required BF000000", result);
    end
  endtask
  task automatic test_timeout();
    int s;
    lat = 1;
    withhold = 2;
    clear_log();
    start_run(2, 32'h40000000, s);
    wait_done("timeout");
    withhold = 0;
    checks++;
    if (err_at_done !== 1'b1 || n_load != 0) begin
      errors++;
      $display("FAIL timeout_abort: got error %b loads %0d, required 1 0", err_at_done, n_load);
    end
    checks++;
    if (done_cyc - mul2_cyc != TIMEOUT + 1) begin
      errors++;
      $display("FAIL timeout_cycles: got %0d, required %0d", done_cyc - mul2_cyc, TIMEOUT + 1);
    end
    @(negedge clk);
    checks++;
    if (bus.error_o !== 1'b1) begin
      errors++;
      $display("FAIL timeout_sticky: got %b, required 1", bus.error_o);
    end
    clear_log();
    start_run(0, 32'h40000000, s);
    checks++;
    if (bus.error_o !== 1'b0 || bus.busy_o !== 1'b1) begin
      errors++;
      $display("FAIL timeout_clear: got error %b busy %b, required 0 1", bus.error_o, bus.busy_o);
    end
    wait_done("timeout_next");
  endtask
  task automatic test_robust();
    int s;
    write_coeff(0, 32'h3F800000);
    lat = 3;
    stray = 1;
    clear_log();
    start_run(2, 32'h40000000, s);
    repeat (4) @(posedge clk);
    #1 bus.start_i = 1'b1; bus.order_i = 3'd0; bus.x_i = 32'h0;
    @(posedge clk); #1 bus.start_i = 1'b0;
    wait_done("robust");
    stray = 0;
    checks++;
    if (n_mul != 3 || n_add != 3 || result !== 32'h41880000) begin
      errors++;
      $display("FAIL robust_run: got mul %0d add %0d result %h, required 3 3 41880000", n_mul, n_add, result);
    end
    checks++;
    if (done_cyc - s != 32) begin
      errors++;
      $display("FAIL robust_latency: got %0d, required 32", done_cyc - s);
    end
    repeat (10) @(negedge clk);
    checks++;
    if (n_done != 1 || bus.busy_o !== 1'b0) begin
      errors++;
      $display("FAIL robust_no_queue: got dones %0d busy %b, required 1 0", n_done, bus.busy_o);
    end
  endtask
  task automatic test_reset_addw();
    int s;
    lat = 3;
    clear_log();
    start_run(2, 32'h40000000, s);
    for (int i = 0; i < 100 && n_add == 0; i++) @(posedge clk);
    #2;
    checks++;
    if (bus.busy_o !== 1'b1) begin
      errors++;
      $display("FAIL addw_busy: got %b, required 1", bus.busy_o);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (outs() !== '0) begin
      errors++;
      $display("FAIL addw_reset_outputs: got %h, required 0", outs());
    end
    #4 rst = 1'b0;
    repeat (10) @(negedge clk);
    checks++;
    if (n_done != 0 || bus.busy_o !== 1'b0) begin
      errors++;
      $display("FAIL addw_stays_idle: got dones %0d busy %b, required 0 0", n_done, bus.busy_o);
    end
  endtask
  task automatic test_back_to_back();
    int s;
    lat = 1;
    clear_log();
    @(posedge clk); #1;
    bus.start_i = 1'b1; bus.order_i = 3'd0; bus.x_i = 32'h40000000;
    bus.coeff_we_i = 1'b1; bus.coeff_waddr_i = 3'd0; bus.coeff_wdata_i = 32'h40A00000;
    s = cyc;
    @(posedge clk); #1;
    bus.start_i = 1'b0; bus.coeff_we_i = 1'b0;
    wait_done("start_write");
    checks++;
    if (result !== 32'h40A00000 || done_cyc - s != 8) begin
      errors++;
      $display("FAIL start_write: got result %h latency %0d, required 40A00000 8", result, done_cyc - s);
    end
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    bus.start_i = 1'b0; bus.x_i = '0; bus.order_i = '0;
    bus.coeff_we_i = 1'b0; bus.coeff_waddr_i = '0; bus.coeff_wdata_i = '0;
    clear_log();
    #12 rst = 1'b0;
    test_reset();
    test_order2();
    test_order0();
    test_timeout();
    test_robust();
    test_reset_addw();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end
endmodule

// File: doc/horner_ctrl.md
Name: horner_ctrl

Overview:
- Sequencing controller that sits directly upstream of the FP32 multiply/add datapath.
- Holds a polynomial coefficient bank and latches an input sample x.
- Drives the datapath's operand and valid/load strobes through a Horner evaluation y = (...(c[n]*x + c[n-1])*x + ...)*x + c[0], waiting on the add/mul done handshakes.
- Reports completion to the requester once the datapath result register holds y.

Parameters:
- DATA_WIDTH, 32, width of the IEEE-754 single-precision operands.
- MAX_ORDER, 7, highest supported polynomial order; the bank holds MAX_ORDER+1 words.
- ADDR_WIDTH, 3, coefficient index width; must satisfy 2**ADDR_WIDTH >= MAX_ORDER+1.
- TIMEOUT, 64, cycles allowed between a valid pulse and its done before aborting.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, asynchronous, active-high.
- start_i  in  1  start request; accepted only in IDLE.
- x_i  in  DATA_WIDTH  sample; latched on accepted start.
- order_i  in  ADDR_WIDTH  polynomial order n; latched on accepted start, clamped to MAX_ORDER.
- coeff_we_i  in  1  coefficient write enable.
- coeff_waddr_i  in  ADDR_WIDTH  coefficient index k.
- coeff_wdata_i  in  DATA_WIDTH  coefficient c[k].
- add_done_i  in  1  datapath adder done.
- mul_done_i  in  1  datapath multiplier done.
- signal_o  out  DATA_WIDTH  multiplier operand to the datapath.
- coeff_o  out  DATA_WIDTH  adder coefficient operand to the datapath.
- add_valid_o  out  1  one-cycle adder start pulse.
- mul_valid_o  out  1  one-cycle multiplier start pulse.
- load_result_o  out  1  one-cycle datapath result-register load.
- busy_o  out  1  high from accepted start until return to IDLE.
- done_o  out  1  one-cycle pulse; datapath result is valid in this cycle.
- error_o  out  1  sticky timeout flag; cleared on the next accepted start.

Behaviour:
- Reset state:
  - All outputs 0 and the FSM in IDLE.
  - Coefficient bank cleared to 0x00000000; latched x, latched n and index k cleared.
- Coefficient writes:
  - A write with coeff_waddr_i > MAX_ORDER is ignored.
  - Writes take effect at the clock edge. They are accepted in any state; a write during a run changes c[k] only for steps not yet set up.
- Operand timing:
  - The datapath registers its operands one cycle before use, so every operation has a SETUP cycle followed by a VALID cycle.
  - Operands are driven in SETUP and held stable through the matching done.
- FSM states and transitions:
  - IDLE: on start_i, latch x and n = min(order_i, MAX_ORDER), set k = n, clear error_o, go to SEED_S.
  - SEED_S: signal_o = 0.0 → SEED_V.
  - SEED_V: mul_valid_o = 1 for one cycle → SEED_W. This zero-seeds the multiplier result.
  - SEED_W: on mul_done_i → ADD_S.
  - ADD_S: coeff_o = c[k] → ADD_V.
  - ADD_V: add_valid_o pulse → ADD_W.
  - ADD_W: on add_done_i: if k == 0 → LOAD; else decrement k → MUL_S.
  - MUL_S: signal_o = x → MUL_V.
  - MUL_V: mul_valid_o pulse → MUL_W.
  - MUL_W: on mul_done_i → ADD_S.
  - LOAD: load_result_o = 1 for one cycle → DONE.
  - DONE: done_o = 1 for one cycle → IDLE.
- Operation counts for order n: exactly n+1 mul_valid pulses and n+1 add_valid pulses. coeff_o presents c[n], c[n-1], ..., c[0] in that order.
- Latency:
  - 5 + 3(n+1) + 3n controller cycles, plus the datapath done latencies, measured from start to done_o.
  - With zero-latency done (done arriving the cycle after valid): start at cycle 0 gives done_o at cycle 6n+8.
- Handshake rules:
  - A done outside its matching wait state is ignored.
  - Both dones asserted in the same cycle: only the one matching the current wait state is acted on.
  - start_i while busy_o is ignored; no queueing.
  - start_i and coeff_we_i in the same cycle: the write lands, and the run reads the new value.
- Order 0: SEED, then a single ADD with c[0], then LOAD and DONE (one mul pulse, one add pulse).
- Timeout:
  - A counter resets on entry to each *_W state.
  - If it reaches TIMEOUT, set error_o, skip LOAD and go to DONE; done_o still pulses.
- Reset mid-operation: immediate return to IDLE with all outputs 0, and the coefficient bank cleared.

Test Plan:
- Reset with rst_i asserted between clock edges: all outputs drop asynchronously to 0, busy_o = 0, and a readback run with order 0 yields coeff_o = 0x00000000.
- Order-2 sequence with c = {c0 = 0x3F800000, c1 = 0x40000000, c2 = 0x40400000}, x = 0x40000000, and done responders of latency 3:
  - Required pulse order is mul(signal 0), add(c2), mul(x), add(c1), mul(x), add(c0), load, done.
  - Exactly 3 mul and 3 add pulses.
- The same run integrated with the datapath: on done_o, result_o = 0x41880000 (17.0).
- Order 0 with c0 = 0xBF000000: one mul pulse and one add pulse; integrated result 0xBF000000; done_o at cycle 8 with zero-latency done.
- Withhold mul_done_i after the second mul_valid: error_o rises after TIMEOUT cycles, done_o pulses with no load_result_o, and the next start clears error_o.
- Robustness and reset cases:
  - start_i pulsed while busy_o and stray add_done_i during MUL_W have no effect on the sequence.
  - rst_i asserted in ADD_W returns to IDLE with all strobes 0.
